// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
//   Shared definitions for the ID/EX stage of the MIPS core:
//     - forwarding mux select encodings driven on Forward_A/B
//     - ALU operation class codes carried from decode to execute
//     - the control bundle carried through the stage and its bubble value
//     - a saturating increment used by the optional hazard statistics
//   No ports (package).
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

    // Operand source selected by the EX-stage forwarding muxes.
    // Code 3 is never produced.
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,   // value read from the register file in ID
        FWD_WB  = 2'd1,   // WBData of the instruction in WB
        FWD_MEM = 2'd2    // ALU result (Address) of the instruction in MEM
    } fwd_sel_e;

    // ALU operation class produced by the main decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,  // loads/stores: address add
        ALUOP_SUB   = 2'b01,  // branches: compare by subtract
        ALUOP_RTYPE = 2'b10,  // R-type: operation taken from funct
        ALUOP_IMM   = 2'b11   // immediate arithmetic/logic
    } alu_op_e;

    // Control signals travelling with an instruction from ID to EX.
    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    reg_dst;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    mem_to_reg;
    } ctrl_t;

    // A bubble: no register write, no memory access, so it has no
    // architectural effect downstream.
    localparam ctrl_t CTRL_BUBBLE = '0;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// -----------------------------------------------------------------------------
// id_ex_stage_fwd_unit
//   Purely combinational forwarding unit. For each EX source register it
//   selects the youngest in-flight producer: MEM beats WB, and register 0 is
//   never forwarded because it is hard-wired to zero.
// Ports:
//   ex_rs_i, ex_rt_i     in   source registers of the instruction in EX
//   mem_reg_write_i      in   MEM-stage instruction writes a register
//   mem_write_reg_i      in   MEM-stage destination register
//   wb_reg_write_i       in   WB-stage instruction writes a register
//   wb_write_reg_i       in   WB-stage destination register
//   forward_a_o          out  operand A source select
//   forward_b_o          out  operand B source select
// -----------------------------------------------------------------------------
module id_ex_stage_fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter int REG_DIR_WIDTH = 3
) (
    input  logic [REG_DIR_WIDTH-1:0] ex_rs_i,
    input  logic [REG_DIR_WIDTH-1:0] ex_rt_i,
    input  logic                     mem_reg_write_i,
    input  logic [REG_DIR_WIDTH-1:0] mem_write_reg_i,
    input  logic                     wb_reg_write_i,
    input  logic [REG_DIR_WIDTH-1:0] wb_write_reg_i,
    output fwd_sel_e                 forward_a_o,
    output fwd_sel_e                 forward_b_o
);

    function automatic fwd_sel_e pick_source(
        input logic [REG_DIR_WIDTH-1:0] src,
        input logic                     mem_we,
        input logic [REG_DIR_WIDTH-1:0] mem_rd,
        input logic                     wb_we,
        input logic [REG_DIR_WIDTH-1:0] wb_rd
    );
        if (src == '0) begin
            return FWD_REG;
        end else if (mem_we && (mem_rd == src)) begin
            return FWD_MEM;
        end else if (wb_we && (wb_rd == src)) begin
            return FWD_WB;
        end else begin
            return FWD_REG;
        end
    endfunction

    assign forward_a_o = pick_source(ex_rs_i, mem_reg_write_i, mem_write_reg_i,
                                     wb_reg_write_i, wb_write_reg_i);
    assign forward_b_o = pick_source(ex_rt_i, mem_reg_write_i, mem_write_reg_i,
                                     wb_reg_write_i, wb_write_reg_i);

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the MIPS core. Captures decoded operands and
//   control from ID and presents them to EX one clock later. Also contains
//   load-use hazard detection (inserts a bubble and freezes PC and IF/ID) and
//   the forwarding unit that drives the EX operand muxes.
//
//   Per-edge priority: reset > hold_i > flush_i > load-use bubble > load ID.
//
// Optional feature (macro HAZ_STATS_EN):
//   When defined, adds stall_cnt / flush_cnt: 16-bit saturating counts of
//   load-use stall cycles and flush bubbles; cleared by reset and frozen
//   while hold_i is high. When undefined these ports do not exist.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   hold_i                     freeze the whole stage (memory wait)
//   flush_i                    branch taken: next contents become a bubble
//   id_*                       decoded operands/control from ID
//   mem_RegWrite, mem_WriteReg MEM-stage destination info for forwarding
//   wb_RegWrite,  wb_WriteReg  WB-stage destination info for forwarding
//   ex_*                       registered operands/control for EX
//                              (Rd -> ex_RegDst1, Rt -> ex_RegDst2)
//   Forward_A, Forward_B       0 = reg file, 1 = WBData, 2 = MEM ALU result
//   stall_cnt, flush_cnt       hazard statistics (HAZ_STATS_EN only)
//   PCWrite, IFIDWrite         0 = hold PC / IF/ID register this cycle
// -----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int EXT_OUT_WIDTH = 8,
    parameter int REG_DIR_WIDTH = 3,
    parameter int PC_WIDTH      = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hold_i,
    input  logic                     flush_i,
    input  logic [DATA_WIDTH-1:0]    id_readd1,
    input  logic [DATA_WIDTH-1:0]    id_readd2,
    input  logic [EXT_OUT_WIDTH-1:0] id_SignExtendOut,
    input  logic [PC_WIDTH-1:0]      id_pc1,
    input  logic [5:0]               id_funct,
    input  logic [REG_DIR_WIDTH-1:0] id_Rs,
    input  logic [REG_DIR_WIDTH-1:0] id_Rt,
    input  logic [REG_DIR_WIDTH-1:0] id_Rd,
    input  logic [1:0]               id_ALUop,
    input  logic                     id_ALUSrc,
    input  logic                     id_RegDst,
    input  logic                     id_MemRead,
    input  logic                     id_MemWrite,
    input  logic                     id_RegWrite,
    input  logic                     id_MemtoReg,
    input  logic                     mem_RegWrite,
    input  logic                     wb_RegWrite,
    input  logic [REG_DIR_WIDTH-1:0] mem_WriteReg,
    input  logic [REG_DIR_WIDTH-1:0] wb_WriteReg,
    output logic [DATA_WIDTH-1:0]    ex_readd1,
    output logic [DATA_WIDTH-1:0]    ex_readd2,
    output logic [EXT_OUT_WIDTH-1:0] ex_SignExtendOut,
    output logic [PC_WIDTH-1:0]      ex_pc1,
    output logic [5:0]               ex_funct,
    output logic [REG_DIR_WIDTH-1:0] ex_Rs,
    output logic [REG_DIR_WIDTH-1:0] ex_RegDst1,
    output logic [REG_DIR_WIDTH-1:0] ex_RegDst2,
    output logic [1:0]               ex_ALUop,
    output logic                     ex_ALUSrc,
    output logic                     ex_RegDst,
    output logic                     ex_MemRead,
    output logic                     ex_MemWrite,
    output logic                     ex_RegWrite,
    output logic                     ex_MemtoReg,
    output logic [1:0]               Forward_A,
    output logic [1:0]               Forward_B,
`ifdef HAZ_STATS_EN
    output logic [15:0]              stall_cnt,
    output logic [15:0]              flush_cnt,
`endif
    output logic                     PCWrite,
    output logic                     IFIDWrite
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    readd1;
        logic [DATA_WIDTH-1:0]    readd2;
        logic [EXT_OUT_WIDTH-1:0] sext;
        logic [PC_WIDTH-1:0]      pc1;
        logic [5:0]               funct;
        logic [REG_DIR_WIDTH-1:0] rs;
        logic [REG_DIR_WIDTH-1:0] rd;
        logic [REG_DIR_WIDTH-1:0] rt;
    } data_t;

    ctrl_t ctrl_q, ctrl_d, id_ctrl;
    data_t data_q, data_d, id_data;
    logic  luse;
    logic  stall;

    always_comb begin
        id_ctrl            = CTRL_BUBBLE;
        id_ctrl.alu_op     = alu_op_e'(id_ALUop);
        id_ctrl.alu_src    = id_ALUSrc;
        id_ctrl.reg_dst    = id_RegDst;
        id_ctrl.mem_read   = id_MemRead;
        id_ctrl.mem_write  = id_MemWrite;
        id_ctrl.reg_write  = id_RegWrite;
        id_ctrl.mem_to_reg = id_MemtoReg;

        id_data        = '0;
        id_data.readd1 = id_readd1;
        id_data.readd2 = id_readd2;
        id_data.sext   = id_SignExtendOut;
        id_data.pc1    = id_pc1;
        id_data.funct  = id_funct;
        id_data.rs     = id_Rs;
        id_data.rd     = id_Rd;
        id_data.rt     = id_Rt;
    end

    // A load in EX whose destination is a source of the instruction in ID.
    // A load into register 0 produces nothing to wait for.
    always_comb begin
        luse  = ctrl_q.mem_read && (data_q.rt != '0) &&
                ((data_q.rt == id_Rs) || (data_q.rt == id_Rt));
        // A taken branch discards the ID instruction, so its hazard is moot;
        // during a hold the front end is frozen anyway.
        stall = luse && !flush_i && !hold_i;
        PCWrite   = !hold_i && !stall;
        IFIDWrite = !hold_i && !stall;
    end

    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (!hold_i) begin
            if (flush_i || luse) begin
                ctrl_d = CTRL_BUBBLE;
                data_d = '0;
            end else begin
                ctrl_d = id_ctrl;
                data_d = id_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_BUBBLE;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

`ifdef HAZ_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall ? sat_inc16(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = (flush_i && !hold_i) ? sat_inc16(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

    assign ex_readd1        = data_q.readd1;
    assign ex_readd2        = data_q.readd2;
    assign ex_SignExtendOut = data_q.sext;
    assign ex_pc1           = data_q.pc1;
    assign ex_funct         = data_q.funct;
    assign ex_Rs            = data_q.rs;
    assign ex_RegDst1       = data_q.rd;
    assign ex_RegDst2       = data_q.rt;
    assign ex_ALUop         = ctrl_q.alu_op;
    assign ex_ALUSrc        = ctrl_q.alu_src;
    assign ex_RegDst        = ctrl_q.reg_dst;
    assign ex_MemRead       = ctrl_q.mem_read;
    assign ex_MemWrite      = ctrl_q.mem_write;
    assign ex_RegWrite      = ctrl_q.reg_write;
    assign ex_MemtoReg      = ctrl_q.mem_to_reg;

    fwd_sel_e fwd_a, fwd_b;

    id_ex_stage_fwd_unit #(
        .REG_DIR_WIDTH(REG_DIR_WIDTH)
    ) u_fwd (
        .ex_rs_i        (data_q.rs),
        .ex_rt_i        (data_q.rt),
        .mem_reg_write_i(mem_RegWrite),
        .mem_write_reg_i(mem_WriteReg),
        .wb_reg_write_i (wb_RegWrite),
        .wb_write_reg_i (wb_WriteReg),
        .forward_a_o    (fwd_a),
        .forward_b_o    (fwd_b)
    );

    assign Forward_A = fwd_a;
    assign Forward_B = fwd_b;

endmodule
